// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative cache controller.
//  - state_t     : controller FSM states
//  - addr_w()    : address width derived from tag and index widths
//  - sets()      : number of sets for a given index width
//  - index_of()  : set-index field of a {tag,index} address
//  - tag_of()    : tag field of a {tag,index} address
// The helpers work on 32-bit values so that they can serve any parameterisation.
// Callers cast the results down to their own field widths.
package cache_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_MISS_RD,
    ST_WR_THRU,
    ST_RESP
  } state_t;

  function automatic int unsigned addr_w(input int unsigned tag_w, input int unsigned index_w);
    return tag_w + index_w;
  endfunction

  function automatic int unsigned sets(input int unsigned index_w);
    return 32'd1 << index_w;
  endfunction

  function automatic logic [31:0] index_of(input logic [31:0] addr, input int unsigned index_w);
    return addr & ((32'd1 << index_w) - 32'd1);
  endfunction

  function automatic logic [31:0] tag_of(input logic [31:0] addr, input int unsigned index_w);
    return addr >> index_w;
  endfunction

endpackage

// File: rtl/cache_way_bank.sv
// One way of the cache: valid bit, tag and data storage for every set.
// Ports:
//  clk      in   clock, rising edge
//  rst      in   asynchronous active-high reset (clears valid bits only)
//  i_index  in   set index for the combinational read and for the write
//  o_valid  out  valid bit at i_index
//  o_tag    out  tag at i_index
//  o_data   out  data at i_index
//  i_we     in   write tag and data at i_index and mark the entry valid
//  i_wtag   in   tag to write
//  i_wdata  in   data to write
//  i_flush  in   clear every valid bit (has priority over i_we)
module cache_way_bank
  import cache_pkg::*;
#(
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned LINE_W  = 64,
  localparam int unsigned SETS   = sets(INDEX_W)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [INDEX_W-1:0] i_index,
  output logic               o_valid,
  output logic [TAG_W-1:0]   o_tag,
  output logic [LINE_W-1:0]  o_data,
  input  logic               i_we,
  input  logic [TAG_W-1:0]   i_wtag,
  input  logic [LINE_W-1:0]  i_wdata,
  input  logic               i_flush
);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_flush) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[i_index] <= 1'b1;
    end
  end

  // Tag/data payload needs no reset: it is meaningless while valid is 0.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[i_index]  <= i_wtag;
      r_data[i_index] <= i_wdata;
    end
  end

  assign o_valid = r_valid[i_index];
  assign o_tag   = r_tag[i_index];
  assign o_data  = r_data[i_index];

endmodule

// File: rtl/assoc_cache_ctrl.sv
// N-way set-associative cache controller between the CPU load/store path and RAM.
// Read misses fill a victim way from RAM; writes are write-through with no
// allocate on miss. One LINE_W word per line.
// Ports:
//  clk, gen_reset            clock; asynchronous active-high reset
//  cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request, accepted when cpu_req & cpu_ready
//  flush                     invalidate all lines (honoured in IDLE only)
//  cpu_ready                 controller idle and not flushing
//  cpu_done/cpu_hit/cpu_rdata  one-cycle completion pulse, hit flag, read data
//  mem_req/mem_we/mem_addr/mem_wdata  RAM request, held until mem_ack
//  mem_rdata/mem_ack         RAM fill data and completion
//  hit_count/miss_count      saturating statistics counters
module assoc_cache_ctrl
  import cache_pkg::*;
#(
  parameter int unsigned WAYS    = 4,
  parameter int unsigned INDEX_W = 10,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned LINE_W  = 64,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned ADDR_W = addr_w(TAG_W, INDEX_W)
) (
  input  logic              clk,
  input  logic              gen_reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [LINE_W-1:0] cpu_wdata,
  input  logic              flush,
  output logic              cpu_ready,
  output logic              cpu_done,
  output logic              cpu_hit,
  output logic [LINE_W-1:0] cpu_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);

  localparam int unsigned SETS  = sets(INDEX_W);
  localparam int unsigned WAY_W = $clog2(WAYS);

  state_t            r_state;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [LINE_W-1:0] r_wdata;
  logic [WAY_W-1:0]  r_rr [SETS];
  logic              r_cpu_done;
  logic              r_cpu_hit;
  logic [LINE_W-1:0] r_rdata;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [CNT_W-1:0]  r_hits;
  logic [CNT_W-1:0]  r_misses;

  logic [INDEX_W-1:0] w_index;
  logic [TAG_W-1:0]   w_tag;
  logic [WAYS-1:0]    w_valid;
  logic [TAG_W-1:0]   w_tag_rd  [WAYS];
  logic [LINE_W-1:0]  w_data_rd [WAYS];
  logic [WAYS-1:0]    w_bank_we;
  logic [LINE_W-1:0]  w_bank_wdata;
  logic               w_flush;
  logic               w_hit;
  logic [WAY_W-1:0]   w_hit_way;
  logic               w_any_inv;
  logic [WAY_W-1:0]   w_victim;
  logic               w_fill;
  logic               w_wr_hit;

  // All lookups, fills and write hits address the captured request's set.
  assign w_index = INDEX_W'(index_of(32'(r_addr), INDEX_W));
  assign w_tag   = TAG_W'(tag_of(32'(r_addr), INDEX_W));
  assign w_flush = (r_state == ST_IDLE) && flush;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    cache_way_bank #(
      .INDEX_W(INDEX_W),
      .TAG_W  (TAG_W),
      .LINE_W (LINE_W)
    ) u_bank (
      .clk    (clk),
      .rst    (gen_reset),
      .i_index(w_index),
      .o_valid(w_valid[g]),
      .o_tag  (w_tag_rd[g]),
      .o_data (w_data_rd[g]),
      .i_we   (w_bank_we[g]),
      .i_wtag (w_tag),
      .i_wdata(w_bank_wdata),
      .i_flush(w_flush)
    );
  end

  // Hit detection: first matching way in ascending order wins.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_hit && w_valid[w] && (w_tag_rd[w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAY_W'(w);
      end
    end
  end

  // Victim: lowest invalid way, otherwise the set's round-robin pointer.
  always_comb begin
    w_any_inv = 1'b0;
    w_victim  = r_rr[w_index];
    for (int unsigned w = 0; w < WAYS; w++) begin
      if (!w_any_inv && !w_valid[w]) begin
        w_any_inv = 1'b1;
        w_victim  = WAY_W'(w);
      end
    end
  end

  assign w_fill       = (r_state == ST_MISS_RD) && r_mem_req && mem_ack;
  assign w_wr_hit     = (r_state == ST_LOOKUP) && r_we && w_hit;
  assign w_bank_wdata = w_fill ? mem_rdata : r_wdata;

  always_comb begin
    w_bank_we = '0;
    for (int unsigned w = 0; w < WAYS; w++) begin
      w_bank_we[w] = (w_fill && (w_victim == WAY_W'(w))) ||
                     (w_wr_hit && (w_hit_way == WAY_W'(w)));
    end
  end

  always_ff @(posedge clk or posedge gen_reset) begin
    if (gen_reset) begin
      r_state    <= ST_IDLE;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cpu_done <= 1'b0;
      r_cpu_hit  <= 1'b0;
      r_rdata    <= '0;
      r_mem_req  <= 1'b0;
      r_mem_we   <= 1'b0;
      r_hits     <= '0;
      r_misses   <= '0;
      for (int unsigned s = 0; s < SETS; s++) r_rr[s] <= '0;
    end else begin
      r_cpu_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (flush) begin
            for (int unsigned s = 0; s < SETS; s++) r_rr[s] <= '0;
          end else if (cpu_req) begin
            r_we    <= cpu_we;
            r_addr  <= cpu_addr;
            r_wdata <= cpu_wdata;
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          r_cpu_hit <= w_hit;
          if (w_hit) begin
            if (r_hits != '1) r_hits <= r_hits + CNT_W'(1);
          end else begin
            if (r_misses != '1) r_misses <= r_misses + CNT_W'(1);
          end
          if (r_we) begin
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b1;
            r_state   <= ST_WR_THRU;
          end else if (w_hit) begin
            r_rdata <= w_data_rd[w_hit_way];
            r_state <= ST_RESP;
          end else begin
            r_mem_req <= 1'b1;
            r_mem_we  <= 1'b0;
            r_state   <= ST_MISS_RD;
          end
        end
        ST_MISS_RD: begin
          if (w_fill) begin
            // Pointer only advances when a valid line is displaced.
            if (!w_any_inv) r_rr[w_index] <= r_rr[w_index] + WAY_W'(1);
            r_rdata   <= mem_rdata;
            r_cpu_hit <= 1'b0;
            r_mem_req <= 1'b0;
            r_state   <= ST_RESP;
          end
        end
        ST_WR_THRU: begin
          if (r_mem_req && mem_ack) begin
            r_mem_req <= 1'b0;
            r_mem_we  <= 1'b0;
            r_state   <= ST_RESP;
          end
        end
        ST_RESP: begin
          r_cpu_done <= 1'b1;
          r_state    <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cpu_ready  = (r_state == ST_IDLE) && !flush;
  assign cpu_done   = r_cpu_done;
  assign cpu_hit    = r_cpu_hit;
  assign cpu_rdata  = r_rdata;
  assign mem_req    = r_mem_req;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_addr;
  assign mem_wdata  = r_wdata;
  assign hit_count  = r_hits;
  assign miss_count = r_misses;

endmodule

// File: tb/tb_assoc_cache_ctrl.sv
module tb_assoc_cache_ctrl;

  localparam int ADDR_W = 18;
  localparam int LINE_W = 64;
  localparam int NSETS  = 1024;
  localparam int NWAYS  = 4;

  logic              clk = 1'b0;
  logic              gen_reset = 1'b1;
  logic              cpu_req = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [LINE_W-1:0] cpu_wdata = '0;
  logic              flush = 1'b0;
  logic [LINE_W-1:0] mem_rdata = '0;
  logic              mem_ack = 1'b0;

  logic              cpu_ready, cpu_done, cpu_hit, mem_req, mem_we;
  logic [LINE_W-1:0] cpu_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       hit_count, miss_count;

  logic              d2_ready, d2_done, d2_hit, d2_mem_req, d2_mem_we;
  logic [LINE_W-1:0] d2_rdata, d2_mem_wdata;
  logic [ADDR_W-1:0] d2_mem_addr;
  logic [1:0]        d2_hit_count, d2_miss_count;

  assoc_cache_ctrl dut (
    .clk(clk), .gen_reset(gen_reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .flush(flush),
    .cpu_ready(cpu_ready), .cpu_done(cpu_done), .cpu_hit(cpu_hit), .cpu_rdata(cpu_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  // Narrow-counter copy fed the same stimulus; only its counters differ.
  assoc_cache_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .gen_reset(gen_reset), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .flush(flush),
    .cpu_ready(d2_ready), .cpu_done(d2_done), .cpu_hit(d2_hit), .cpu_rdata(d2_rdata),
    .mem_req(d2_mem_req), .mem_we(d2_mem_we), .mem_addr(d2_mem_addr), .mem_wdata(d2_mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_count(d2_hit_count), .miss_count(d2_miss_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // ---------------- behavioural reference model ----------------
  bit          m_valid [NSETS][NWAYS];
  logic [7:0]  m_tag   [NSETS][NWAYS];
  logic [63:0] m_data  [NSETS][NWAYS];
  int          m_rr    [NSETS];
  int          m_hits, m_misses;

  task automatic model_flush();
    for (int s = 0; s < NSETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < NWAYS; w++) m_valid[s][w] = 1'b0;
    end
  endtask

  task automatic model_reset();
    model_flush();
    m_hits = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input logic we, input logic [17:0] a, input logic [63:0] wd,
                              input logic [63:0] fill, output logic hit, output logic [63:0] rd);
    int set, way, vic;
    logic [7:0] tag;
    set = int'(a) % NSETS;
    tag = 8'(int'(a) / NSETS);
    way = -1;
    rd  = '0;
    for (int w = 0; w < NWAYS; w++)
      if (way < 0 && m_valid[set][w] && m_tag[set][w] == tag) way = w;
    hit = (way >= 0);
    if (hit) begin
      m_hits++;
      if (we) m_data[set][way] = wd;
      else    rd = m_data[set][way];
    end else begin
      m_misses++;
      if (!we) begin
        vic = -1;
        for (int w = 0; w < NWAYS; w++)
          if (vic < 0 && !m_valid[set][w]) vic = w;
        if (vic < 0) begin
          vic = m_rr[set];
          m_rr[set] = (m_rr[set] + 1) % NWAYS;
        end
        m_valid[set][vic] = 1'b1;
        m_tag[set][vic]   = tag;
        m_data[set][vic]  = fill;
        rd = fill;
      end
    end
  endtask

  // ---------------- drivers (all called #1 after a rising edge) ----------------
  task automatic do_reset();
    gen_reset = 1'b1;
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    flush = 1'b0;
    @(posedge clk); #1;
    gen_reset = 1'b0;
    model_reset();
  endtask

  task automatic issue(input logic we, input logic [17:0] a, input logic [63:0] d);
    int n;
    n = 0;
    while (!cpu_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!cpu_ready) check("ready_timeout", 64'(cpu_ready), 64'(1));
    cpu_req = 1'b1;
    cpu_we = we;
    cpu_addr = a;
    cpu_wdata = d;
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_op(input logic we, input logic [17:0] a, input logic [63:0] d,
                       input logic [63:0] fill, input int ack_dly,
                       output logic hit, output logic [63:0] rd, output int lat,
                       output logic saw_mem, output logic mwe,
                       output logic [17:0] maddr, output logic [63:0] mwd);
    int  wait_n;
    bit  done;
    wait_n = 0;
    done = 0;
    hit = 1'b0; rd = '0; saw_mem = 1'b0; mwe = 1'b0; maddr = '0; mwd = '0;
    issue(we, a, d);
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (cpu_done) begin
        done = 1;
        hit = cpu_hit;
        rd = cpu_rdata;
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (!saw_mem) begin
          saw_mem = 1'b1;
          mwe = mem_we;
          maddr = mem_addr;
          mwd = mem_wdata;
        end
        if (wait_n >= ack_dly) begin
          mem_ack = 1'b1;
          mem_rdata = fill;
        end else begin
          wait_n++;
        end
      end else begin
        mem_ack = 1'b0;
      end
    end
    if (!done) check("done_timeout", 64'(done), 64'(1));
  endtask

  typedef struct {
    logic        rst;
    logic        we;
    logic [17:0] addr;
    logic [63:0] wdata;
    logic [63:0] fill;
    logic        exp_hit;
    logic [63:0] exp_rdata;
    int          exp_lat;
    int          exp_hits;
    int          exp_misses;
  } vec_t;

  vec_t tbl[14];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic        hit, saw, mwe, h2;
    logic [63:0] rd, mwd, rd2;
    logic [17:0] maddr;
    int          lat, nseen;
    bit          seen;

    tbl[0]  = '{1'b0, 1'b0, 18'h00123, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0, 64'hDEAD_BEEF_0000_0001, 3, 0, 1};
    tbl[1]  = '{1'b0, 1'b0, 18'h00123, 64'h0, 64'h0, 1'b1, 64'hDEAD_BEEF_0000_0001, 2, 1, 1};
    tbl[2]  = '{1'b1, 1'b0, 18'h00405, 64'h0, 64'h1111, 1'b0, 64'h1111, 3, 0, 1};
    tbl[3]  = '{1'b0, 1'b0, 18'h00805, 64'h0, 64'h2222, 1'b0, 64'h2222, 3, 0, 2};
    tbl[4]  = '{1'b0, 1'b0, 18'h00C05, 64'h0, 64'h3333, 1'b0, 64'h3333, 3, 0, 3};
    tbl[5]  = '{1'b0, 1'b0, 18'h01005, 64'h0, 64'h4444, 1'b0, 64'h4444, 3, 0, 4};
    tbl[6]  = '{1'b0, 1'b0, 18'h01405, 64'h0, 64'h5555, 1'b0, 64'h5555, 3, 0, 5};
    tbl[7]  = '{1'b0, 1'b0, 18'h00405, 64'h0, 64'h6666, 1'b0, 64'h6666, 3, 0, 6};
    tbl[8]  = '{1'b0, 1'b1, 18'h00405, 64'h55, 64'h0, 1'b1, 64'h0, 3, 1, 6};
    tbl[9]  = '{1'b0, 1'b0, 18'h00405, 64'h0, 64'h0, 1'b1, 64'h55, 2, 2, 6};
    tbl[10] = '{1'b0, 1'b1, 18'h3FFFF, 64'h77, 64'h0, 1'b0, 64'h0, 3, 2, 7};
    tbl[11] = '{1'b0, 1'b0, 18'h3FFFF, 64'h0, 64'h88, 1'b0, 64'h88, 3, 2, 8};
    tbl[12] = '{1'b0, 1'b0, 18'h00C05, 64'h0, 64'h0, 1'b1, 64'h3333, 2, 3, 8};
    tbl[13] = '{1'b0, 1'b0, 18'h00805, 64'h0, 64'h9999, 1'b0, 64'h9999, 3, 3, 9};

    // Reset state
    #1;
    check("rst_done",   64'(cpu_done),   64'(0));
    check("rst_hit",    64'(cpu_hit),    64'(0));
    check("rst_memreq", 64'(mem_req),    64'(0));
    check("rst_memwe",  64'(mem_we),     64'(0));
    check("rst_rdata",  64'(cpu_rdata),  64'(0));
    check("rst_hits",   64'(hit_count),  64'(0));
    check("rst_misses", 64'(miss_count), 64'(0));
    @(posedge clk); #1;
    gen_reset = 1'b0;
    check("rst_ready",  64'(cpu_ready),  64'(1));

    // Directed vectors
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      do_op(tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].fill, 0, hit, rd, lat, saw, mwe, maddr, mwd);
      check($sformatf("v%0d_hit", i), 64'(hit), 64'(tbl[i].exp_hit));
      if (!tbl[i].we) check($sformatf("v%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("v%0d_latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      check($sformatf("v%0d_memreq", i), 64'(saw), 64'(tbl[i].we || !tbl[i].exp_hit));
      if (saw) begin
        check($sformatf("v%0d_memwe", i), 64'(mwe), 64'(tbl[i].we));
        check($sformatf("v%0d_memaddr", i), 64'(maddr), 64'(tbl[i].addr));
        if (tbl[i].we) check($sformatf("v%0d_memwdata", i), mwd, tbl[i].wdata);
      end
      check($sformatf("v%0d_hits", i), 64'(hit_count), 64'(tbl[i].exp_hits));
      check($sformatf("v%0d_misses", i), 64'(miss_count), 64'(tbl[i].exp_misses));
      check($sformatf("v%0d_hits_sat2", i), 64'(d2_hit_count), 64'(sat(tbl[i].exp_hits, 3)));
      @(posedge clk); #1;
      check($sformatf("v%0d_done_pulse", i), 64'(cpu_done), 64'(0));
    end

    // flush together with a request: request not taken, lines invalidated
    flush = 1'b1;
    cpu_req = 1'b1;
    cpu_we = 1'b0;
    cpu_addr = 18'h00405;
    #1;
    check("flush_ready_low", 64'(cpu_ready), 64'(0));
    @(posedge clk); #1;
    flush = 1'b0;
    cpu_req = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (cpu_done || mem_req) seen = 1;
      @(posedge clk); #1;
    end
    check("flush_req_dropped", 64'(seen), 64'(0));
    check("flush_keeps_hits", 64'(hit_count), 64'(3));
    do_op(1'b0, 18'h00405, 64'h0, 64'hAAAA, 1, hit, rd, lat, saw, mwe, maddr, mwd);
    check("after_flush_hit", 64'(hit), 64'(0));
    check("after_flush_rdata", rd, 64'hAAAA);
    check("after_flush_misses", 64'(miss_count), 64'(10));

    // Reset in the middle of a read miss
    issue(1'b0, 18'h02222, 64'h0);
    nseen = 0;
    while (!mem_req && nseen < 10) begin
      @(posedge clk); #1;
      nseen++;
    end
    check("midrst_memreq_seen", 64'(mem_req), 64'(1));
    gen_reset = 1'b1;
    #1;
    check("midrst_memreq_async", 64'(mem_req), 64'(0));
    check("midrst_misses", 64'(miss_count), 64'(0));
    @(posedge clk); #1;
    gen_reset = 1'b0;
    model_reset();
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      if (cpu_done || mem_req) seen = 1;
      @(posedge clk); #1;
    end
    check("midrst_no_done", 64'(seen), 64'(0));
    do_op(1'b0, 18'h02222, 64'h0, 64'hBBBB, 0, hit, rd, lat, saw, mwe, maddr, mwd);
    check("midrst_reread_hit", 64'(hit), 64'(0));
    check("midrst_reread_mem", 64'(saw), 64'(1));

    // Counter saturation on the 2-bit copy
    do_reset();
    do_op(1'b0, 18'h00100, 64'h0, 64'h1234, 0, hit, rd, lat, saw, mwe, maddr, mwd);
    for (int k = 0; k < 5; k++)
      do_op(1'b0, 18'h00100, 64'h0, 64'h0, 0, hit, rd, lat, saw, mwe, maddr, mwd);
    check("sat16_hits", 64'(hit_count), 64'(5));
    check("sat2_hits", 64'(d2_hit_count), 64'(3));
    check("sat2_misses", 64'(d2_miss_count), 64'(1));

    // Randomised traffic against the reference model
    do_reset();
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        model_flush();
      end else begin
        logic        we;
        logic [17:0] a;
        logic [63:0] wd, fill;
        int          dly;
        we   = ($urandom_range(0, 2) == 0);
        a    = 18'($urandom_range(0, 5) * NSETS + $urandom_range(0, 3));
        wd   = {$urandom, $urandom};
        fill = {$urandom, $urandom};
        dly  = $urandom_range(0, 3);
        model_access(we, a, wd, fill, h2, rd2);
        do_op(we, a, wd, fill, dly, hit, rd, lat, saw, mwe, maddr, mwd);
        check($sformatf("r%0d_hit", n), 64'(hit), 64'(h2));
        if (!we) check($sformatf("r%0d_rdata", n), rd, rd2);
        check($sformatf("r%0d_memreq", n), 64'(saw), 64'(we || !h2));
        if (saw) begin
          check($sformatf("r%0d_memwe", n), 64'(mwe), 64'(we));
          check($sformatf("r%0d_memaddr", n), 64'(maddr), 64'(a));
          if (we) check($sformatf("r%0d_memwdata", n), mwd, wd);
        end
        check($sformatf("r%0d_hits", n), 64'(hit_count), 64'(sat(m_hits, 65535)));
        check($sformatf("r%0d_misses", n), 64'(miss_count), 64'(sat(m_misses, 65535)));
        check($sformatf("r%0d_hits2", n), 64'(d2_hit_count), 64'(sat(m_hits, 3)));
        check($sformatf("r%0d_misses2", n), 64'(d2_miss_count), 64'(sat(m_misses, 3)));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
